// File: rtl/vga_pkg.sv
// Shared definitions for the sfifo write/read arbiters: the arbiter state
// encoding and the round-robin scan used to choose the next grant holder.
package vga_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // Widest requester set the round-robin helper handles.
  localparam int RR_MAX_NR = 16;
  localparam int RR_MAX_LG = 4;

  // Returns the first set bit of req, scanning last+1, last+2, ... modulo nr.
  // Returns 0 when req is empty; callers qualify the result with |req.
  function automatic logic [RR_MAX_LG-1:0] rr_pick(
    input logic [RR_MAX_NR-1:0] req,
    input logic [RR_MAX_LG-1:0] last,
    input int                   nr
  );
    logic [RR_MAX_LG-1:0] pick;
    int                   idx;
    pick = '0;
    // Walk from the farthest candidate back to the nearest so the nearest
    // requester after 'last' wins.
    for (int k = RR_MAX_NR; k >= 1; k--) begin
      if (k <= nr) begin
        idx = (int'(last) + k) % nr;
        if (req[idx[RR_MAX_LG-1:0]]) pick = idx[RR_MAX_LG-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick_next.sv
// Combinational round-robin priority rotate: picks the next requester after
// 'last'. Shared by the write arbiter and the read-side arbiters.
module rr_pick_next
  import vga_pkg::*;
#(
  parameter int NR   = 4,
  parameter int LGNR = 2
) (
  input  logic [NR-1:0]   req,
  input  logic [LGNR-1:0] last,
  output logic [LGNR-1:0] pick,
  output logic            any
);

  assign pick = LGNR'(rr_pick(RR_MAX_NR'(req), RR_MAX_LG'(last), NR));
  assign any  = |req;

endmodule

// File: rtl/sfifo_write_arbiter.sv
// Shares one sfifo write port among NR valid/ready/last requesters. A winner
// holds the port until it ends its burst with last or reaches MAXBURST words;
// every written word carries the source ID in its top bits.
module sfifo_write_arbiter
  import vga_pkg::*;
#(
  parameter int BW       = 8,
  parameter int NR       = 4,
  parameter int LGNR     = 2,
  parameter int MAXBURST = 8,
  parameter int LGFLEN   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NR-1:0]        i_valid,
  input  logic [NR*BW-1:0]     i_data,
  input  logic [NR-1:0]        i_last,
  output logic [NR-1:0]        o_ready,
  output logic                 o_wr,
  output logic [LGNR+BW-1:0]   o_wr_data,
  input  logic                 i_full,
  input  logic [LGFLEN:0]      i_fill,
  output logic [LGFLEN:0]      o_level,
  output logic [LGNR-1:0]      o_owner,
  output logic                 o_busy
);

  localparam int CW = $clog2(MAXBURST) + 1;

  arb_state_t       state_q, state_d;
  logic [LGNR-1:0]  owner_q, owner_d;
  logic [LGNR-1:0]  rr_last_q, rr_last_d;
  logic [CW-1:0]    count_q, count_d;

  logic [LGNR-1:0]  pick;
  logic             any_valid;
  logic [BW-1:0]    lane [NR];
  logic             accept;
  logic             release_burst;

  rr_pick_next #(
    .NR   (NR),
    .LGNR (LGNR)
  ) u_pick (
    .req  (i_valid),
    .last (rr_last_q),
    .pick (pick),
    .any  (any_valid)
  );

  // Split the flat requester data bus into one lane per requester.
  always_comb begin
    for (int n = 0; n < NR; n++) lane[n] = i_data[n*BW +: BW];
  end

  // Handshake, write datapath and next-state logic, all from registered state.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    owner_d       = owner_q;
    rr_last_d     = rr_last_q;
    count_d       = count_q;
    o_ready       = '0;
    accept        = 1'b0;
    release_burst = 1'b0;

    // Reset aborts a burst in the same cycle: no ready, no write.
    if (state_q == ST_BURST && !i_reset) begin
      o_ready[owner_q] = !i_full;
      accept           = i_valid[owner_q] && !i_full;
      release_burst    = accept && (i_last[owner_q] || count_q == CW'(MAXBURST - 1));
    end

    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          owner_d = pick;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (release_burst) begin
          state_d   = ST_IDLE;
          rr_last_d = owner_q;
          count_d   = '0;
        end else if (accept) begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (i_reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_last_q <= LGNR'(NR - 1);
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      count_q   <= count_d;
    end
  end

  assign o_wr      = accept;
  assign o_wr_data = {owner_q, lane[owner_q]};
  assign o_owner   = owner_q;
  assign o_busy    = (state_q == ST_BURST);
  assign o_level   = i_fill;

endmodule

// File: tb/tb_sfifo_write_arbiter.sv
// Directed bench for sfifo_write_arbiter driving a behavioural 16-deep sfifo
// (no write on full) and four queue-backed valid/ready/last requesters.
module tb_sfifo_write_arbiter;

  localparam int BW = 8, NR = 4, LGNR = 2, MAXBURST = 8, LGFLEN = 4, DEPTH = 16;
  localparam int WW = LGNR + BW;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic [NR-1:0]     valid, last, hold;
  logic [NR*BW-1:0]  data;
  logic [NR-1:0]     o_ready;
  logic              o_wr;
  logic [WW-1:0]     o_wr_data;
  logic              full;
  logic [LGFLEN:0]   fill, o_level;
  logic [LGNR-1:0]   o_owner;
  logic              o_busy;

  // sfifo model state and observation logs
  logic [WW-1:0]     mem [DEPTH];
  logic [LGFLEN:0]   wptr, rptr;
  logic              rd;
  logic              busy_d;
  int                dropped = 0;
  logic [WW-1:0]     wr_log [$];
  logic [WW-1:0]     rd_log [$];
  logic [LGNR-1:0]   gnt_log [$];

  // Requester word queues, each entry {last, data}
  logic [BW:0]       src [NR][$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  sfifo_write_arbiter #(
    .BW(BW), .NR(NR), .LGNR(LGNR), .MAXBURST(MAXBURST), .LGFLEN(LGFLEN)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_valid   (valid),
    .i_data    (data),
    .i_last    (last),
    .o_ready   (o_ready),
    .o_wr      (o_wr),
    .o_wr_data (o_wr_data),
    .i_full    (full),
    .i_fill    (fill),
    .o_level   (o_level),
    .o_owner   (o_owner),
    .o_busy    (o_busy)
  );

  assign fill = wptr - rptr;
  assign full = (fill == (LGFLEN + 1)'(DEPTH));

  // Behavioural sfifo plus grant/write logging.
  always @(posedge i_clk) begin
    if (i_reset) begin
      wptr   <= '0;
      rptr   <= '0;
      busy_d <= 1'b0;
      if (o_wr) dropped <= dropped + 1;
    end else begin
      busy_d <= o_busy;
      if (o_busy && !busy_d) gnt_log.push_back(o_owner);
      if (o_wr) begin
        if (full) dropped <= dropped + 1;
        else begin
          mem[wptr[LGFLEN-1:0]] <= o_wr_data;
          wptr <= wptr + 1'b1;
          wr_log.push_back(o_wr_data);
        end
      end
      if (rd && fill != 0) begin
        rd_log.push_back(mem[rptr[LGFLEN-1:0]]);
        rptr <= rptr + 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int n = 0; n < NR; n++) begin
      if (src[n].size() != 0 && !hold[n]) begin
        valid[n]          = 1'b1;
        data[n*BW +: BW]  = src[n][0][BW-1:0];
        last[n]           = src[n][0][BW];
      end else begin
        valid[n]          = 1'b0;
        data[n*BW +: BW]  = '0;
        last[n]           = 1'b0;
      end
    end
  endtask

  // Second half of a cycle: capture the handshake, cross the edge, advance.
  task automatic post_neg();
    logic [NR-1:0] hs;
    hs = o_ready & valid;
    @(posedge i_clk);
    #1;
    for (int n = 0; n < NR; n++) if (hs[n]) void'(src[n].pop_front());
    drive();
  endtask

  task automatic cycle();
    @(negedge i_clk);
    post_neg();
  endtask

  function automatic logic pending();
    logic p;
    p = o_busy;
    for (int n = 0; n < NR; n++) if (src[n].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic run_idle(input string tag, input int bound);
    for (int i = 0; i < bound && pending(); i++) cycle();
    check({tag, "_done"}, 32'(pending()), 0);
  endtask

  task automatic push_burst(input int n, input logic [BW-1:0] base, input int len);
    for (int i = 0; i < len; i++) src[n].push_back({logic'(i == len - 1), base + BW'(i)});
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    gnt_log.delete();
  endtask

  task automatic drain();
    rd = 1'b1;
    for (int i = 0; i < 60 && fill != 0; i++) cycle();
    rd = 1'b0;
    check("drain_empty", 32'(fill), 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    rd      = 1'b0;
    hold    = '0;
    for (int n = 0; n < NR; n++) src[n].delete();
    drive();
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    check("rst_busy",  32'(o_busy),  0);
    check("rst_ready", 32'(o_ready), 0);
    check("rst_wr",    32'(o_wr),    0);
    check("rst_owner", 32'(o_owner), 0);
    i_reset = 1'b0;
    clear_logs();
  endtask

  logic [WW-1:0]   exp_w;
  logic [WW-1:0]   t2_words [5] = '{10'h0A0, 10'h1A1, 10'h2A2, 10'h3A3, 10'h0A4};
  logic [LGNR-1:0] t2_gnts  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [LGNR-1:0] t3_gnts  [4] = '{2'd2, 2'd3, 2'd2, 2'd2};

  initial begin
    valid = '0; last = '0; data = '0; hold = '0; rd = 1'b0;

    // 1. Single requester: one-cycle arbitration, tagged words, back to idle
    do_reset();
    push_burst(1, 8'h11, 3);
    drive();
    @(negedge i_clk);
    check("t1_idle_busy",  32'(o_busy),  0);
    check("t1_idle_ready", 32'(o_ready), 0);
    check("t1_idle_wr",    32'(o_wr),    0);
    post_neg();
    @(negedge i_clk);
    check("t1_busy",  32'(o_busy),    1);
    check("t1_owner", 32'(o_owner),   1);
    check("t1_ready", 32'(o_ready),   32'b0010);
    check("t1_wr",    32'(o_wr),      1);
    check("t1_data",  32'(o_wr_data), 32'h111);
    post_neg();
    run_idle("t1", 20);
    check("t1_nwords", wr_log.size(), 3);
    check("t1_fill",   32'(fill),     3);
    check("t1_level",  32'(o_level),  3);
    drain();
    check("t1_nread", rd_log.size(), 3);
    for (int i = 0; i < 3 && i < rd_log.size(); i++) check("t1_rd_word", 32'(rd_log[i]), 32'h111 + i);

    // 2. Round-robin over four requesters with 1-word bursts
    do_reset();
    push_burst(0, 8'hA0, 1);
    push_burst(0, 8'hA4, 1);
    push_burst(1, 8'hA1, 1);
    push_burst(2, 8'hA2, 1);
    push_burst(3, 8'hA3, 1);
    drive();
    rd = 1'b1;
    run_idle("t2", 40);
    rd = 1'b0;
    check("t2_ngrant", gnt_log.size(), 5);
    check("t2_nwords", wr_log.size(), 5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) check("t2_grant", 32'(gnt_log[i]), 32'(t2_gnts[i]));
    for (int i = 0; i < 5 && i < wr_log.size(); i++) check("t2_word", 32'(wr_log[i]), 32'(t2_words[i]));
    drain();

    // 3. MAXBURST cap: req2 streams 20 words, req3 gets in after 8
    clear_logs();
    push_burst(2, 8'h20, 20);
    push_burst(3, 8'h33, 1);
    drive();
    rd = 1'b1;
    run_idle("t3", 80);
    rd = 1'b0;
    check("t3_nwords", wr_log.size(), 21);
    check("t3_ngrant", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) check("t3_grant", 32'(gnt_log[i]), 32'(t3_gnts[i]));
    for (int j = 0; j < 21 && j < wr_log.size(); j++) begin
      if (j < 8)       exp_w = 10'h220 + WW'(j);
      else if (j == 8) exp_w = 10'h333;
      else             exp_w = 10'h220 + WW'(j - 1);
      check("t3_word", 32'(wr_log[j]), 32'(exp_w));
    end
    drain();

    // 4. Full stall: 20 words into a 16-deep FIFO with no reads
    clear_logs();
    push_burst(0, 8'h40, 20);
    drive();
    repeat (25) cycle();
    check("t4_fill",   32'(fill),    16);
    check("t4_level",  32'(o_level), 16);
    check("t4_ready",  32'(o_ready), 0);
    check("t4_busy",   32'(o_busy),  1);
    check("t4_owner",  32'(o_owner), 0);
    check("t4_wr",     32'(o_wr),    0);
    check("t4_nwords", wr_log.size(), 16);
    rd = 1'b1;
    repeat (4) cycle();
    rd = 1'b0;
    run_idle("t4", 40);
    check("t4_nwords_end", wr_log.size(), 20);
    check("t4_fill_end",   32'(fill),     16);
    check("t4_dropped",    32'(dropped),  0);
    for (int i = 0; i < 20 && i < wr_log.size(); i++) check("t4_word", 32'(wr_log[i]), 32'h040 + i);
    drain();
    check("t4_nread", rd_log.size(), 20);
    for (int i = 0; i < 20 && i < rd_log.size(); i++) check("t4_rd_word", 32'(rd_log[i]), 32'h040 + i);

    // 5. Reset during word 3 of a req1 burst
    clear_logs();
    push_burst(1, 8'h51, 5);
    drive();
    rd = 1'b1;
    for (int i = 0; i < 20 && wr_log.size() < 2; i++) cycle();
    check("t5_pre_words", wr_log.size(), 2);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("t5_rst_wr",    32'(o_wr),    0);
    check("t5_rst_ready", 32'(o_ready), 0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    for (int n = 0; n < NR; n++) src[n].delete();
    drive();
    check("t5_busy",    32'(o_busy),  0);
    check("t5_ready",   32'(o_ready), 0);
    check("t5_wr",      32'(o_wr),    0);
    check("t5_dropped", 32'(dropped), 0);
    clear_logs();
    push_burst(0, 8'h5A, 1);
    push_burst(1, 8'h5B, 1);
    drive();
    run_idle("t5", 20);
    check("t5_ngrant", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check("t5_grant0", 32'(gnt_log[0]), 0);
      check("t5_grant1", 32'(gnt_log[1]), 1);
    end
    check("t5_nwords", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("t5_word0", 32'(wr_log[0]), 32'h05A);
      check("t5_word1", 32'(wr_log[1]), 32'h15B);
    end
    drain();

    // 6. Owner gap: req3 drops valid for 5 cycles mid-burst, req0 waiting
    clear_logs();
    push_burst(3, 8'h61, 6);
    push_burst(0, 8'h70, 1);
    drive();
    rd = 1'b1;
    for (int i = 0; i < 20 && wr_log.size() < 2; i++) cycle();
    check("t6_pre_words", wr_log.size(), 2);
    hold[3] = 1'b1;
    drive();
    repeat (5) begin
      @(negedge i_clk);
      check("t6_gap_busy",  32'(o_busy),  1);
      check("t6_gap_owner", 32'(o_owner), 3);
      check("t6_gap_ready", 32'(o_ready), 32'b1000);
      check("t6_gap_wr",    32'(o_wr),    0);
      post_neg();
    end
    hold[3] = 1'b0;
    drive();
    run_idle("t6", 40);
    rd = 1'b0;
    check("t6_nwords", wr_log.size(), 7);
    for (int i = 0; i < 6 && i < wr_log.size(); i++) check("t6_word", 32'(wr_log[i]), 32'h361 + i);
    if (wr_log.size() == 7) check("t6_word_req0", 32'(wr_log[6]), 32'h070);
    check("t6_ngrant", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check("t6_grant0", 32'(gnt_log[0]), 3);
      check("t6_grant1", 32'(gnt_log[1]), 0);
    end
    check("t6_dropped", 32'(dropped), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
